// File: rtl/adh_dose_sched.sv
// ADH dose scheduler: averages BP sample windows, maps the average to an ADH target,
// slews the delivered level toward it and waits for acknowledgement. ADH_BP_ALARM_EN adds the alarm.
module adh_dose_sched #(
  parameter int unsigned AVG_LOG2  = 2,
  parameter int unsigned RAMP_STEP = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bp_valid,
  input  logic [8:0]          bp_data,
  output logic                bp_ready,
  output logic [8:0]          adh_target,
  output logic [8:0]          adh_level,
  output logic                dose_req,
  input  logic                dose_ack,
  output logic [AVG_LOG2-1:0] win_cnt,
  output logic                bp_alarm
);

  localparam int unsigned AccW = 9 + AVG_LOG2;
  localparam logic [8:0]  Step = 9'(RAMP_STEP);

  typedef enum logic [2:0] {StIdle, StAccum, StCompute, StRamp, StHold} state_e;

  state_e              r_state, w_state_next;
  logic [AccW-1:0]     r_acc;
  logic [AVG_LOG2-1:0] r_win_cnt;
  logic [8:0]          r_target, r_level;

  logic       w_xfer, w_win_done, w_avg_low;
  logic [8:0] w_avg, w_target_calc, w_diff, w_step;

  assign w_xfer     = (r_state == StAccum) && bp_valid;
  assign w_win_done = w_xfer && (r_win_cnt == {AVG_LOG2{1'b1}});
  assign w_avg      = 9'(r_acc >> AVG_LOG2);
  assign w_avg_low  = (w_avg <= 9'd20);

  // Linear segment only applies for avg in 21..45, so 4*avg fits in 9 bits.
  always_comb begin
    w_target_calc = 9'd0;
    if (w_avg_low) begin
      w_target_calc = 9'd100;
    end else if (w_avg <= 9'd45) begin
      w_target_calc = 9'd180 - {w_avg[6:0], 2'b00};
    end
  end

  assign w_diff = (r_level < r_target) ? (r_target - r_level) : (r_level - r_target);
  assign w_step = (w_diff > Step) ? Step : w_diff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    w_state_next = StAccum;
      StAccum:   if (w_win_done) w_state_next = StCompute;
      StCompute: w_state_next = StRamp;
      StRamp:    if (r_level == r_target) w_state_next = StHold;
      StHold:    if (dose_ack) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= '0;
      r_win_cnt <= '0;
      r_target  <= '0;
      r_level   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          r_acc     <= '0;
          r_win_cnt <= '0;
        end
        StAccum: begin
          if (w_xfer) begin
            r_acc     <= r_acc + AccW'(bp_data);
            r_win_cnt <= r_win_cnt + 1'b1;
          end
        end
        StCompute: r_target <= w_target_calc;
        StRamp: begin
          if (r_level < r_target) begin
            r_level <= r_level + w_step;
          end else if (r_level > r_target) begin
            r_level <= r_level - w_step;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ADH_BP_ALARM_EN
  logic r_low_prev, r_alarm;

  // Alarm latches on two consecutive low windows; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_low_prev <= 1'b0;
      r_alarm    <= 1'b0;
    end else if (r_state == StCompute) begin
      r_low_prev <= w_avg_low;
      if (w_avg_low && r_low_prev) r_alarm <= 1'b1;
    end
  end

  assign bp_alarm = r_alarm;
`else
  assign bp_alarm = 1'b0;
`endif

  assign bp_ready   = (r_state == StAccum);
  assign dose_req   = (r_state == StHold);
  assign adh_target = r_target;
  assign adh_level  = r_level;
  assign win_cnt    = r_win_cnt;

endmodule

// File: doc/adh_dose_sched.md
Name: adh_dose_sched

Overview:
- Sequencing controller for the ADH response datapath.
- Collects blood-pressure samples through a valid/ready handshake and averages them over a fixed window.
- Maps the window average to an ADH target with the team's piecewise law: BP<=20 gives 100, BP>45 gives 0, otherwise 180-4*BP.
- Slews the delivered ADH level toward the target in bounded steps, then requests downstream acknowledgement before taking the next window.

Parameters:
- AVG_LOG2, 2, log2 of samples per averaging window (window = 4 samples).
- RAMP_STEP, 5, maximum change of adh_level per clock in RAMP (1..100).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- bp_valid  input  1  BP sample present on bp_data.
- bp_data  input  9  BP sample, unsigned integer.
- bp_ready  output  1  controller accepts a sample this cycle.
- adh_target  output  9  target ADH for the current window.
- adh_level  output  9  delivered ADH level, slewed.
- dose_req  output  1  adh_level has reached adh_target; awaiting ack.
- dose_ack  input  1  downstream accepts the dose.
- win_cnt  output  AVG_LOG2  samples accepted in the current window.
- bp_alarm  output  1  sticky hypotension alarm (see Optional Feature).

Behaviour:
- Reset (async, rst=1) forces: state IDLE, adh_level=0, adh_target=0, dose_req=0, bp_ready=0, win_cnt=0, accumulator=0, bp_alarm=0.
- States: IDLE, ACCUM, COMPUTE, RAMP, HOLD.
- IDLE:
  - Clears the accumulator and win_cnt.
  - Moves to ACCUM the next cycle.
- ACCUM:
  - bp_ready=1.
  - A transfer occurs when bp_valid&&bp_ready. On a transfer, the accumulator adds bp_data and win_cnt increments.
  - Accumulator width is 9+AVG_LOG2 bits and never overflows.
  - The transfer that completes the window (win_cnt == 2^AVG_LOG2-1) moves to COMPUTE. win_cnt wraps to 0.
  - bp_ready=0 in every state except ACCUM.
- COMPUTE (1 cycle):
  - avg = accumulator >> AVG_LOG2, truncating.
  - adh_target = 100 if avg<=20; 0 if avg>45; else 180-4*avg. Result always lies in 0..100.
  - Moves to RAMP.
- RAMP:
  - Each cycle, if adh_level<adh_target, adh_level += min(RAMP_STEP, target-level). If adh_level>adh_target, adh_level -= min(RAMP_STEP, level-target).
  - adh_level never overshoots the target.
  - The cycle after adh_level==adh_target, the state moves to HOLD. If they are already equal on entry, RAMP lasts 1 cycle.
- HOLD:
  - dose_req=1. adh_level and adh_target are held.
  - dose_ack sampled high moves to IDLE, and dose_req deasserts the next cycle.
  - dose_ack asserted in any state other than HOLD is ignored.
- Latency: last sample accepted at cycle N gives adh_target valid at N+2 and dose_req at N+3+ceil(|delta|/RAMP_STEP).
- Reset mid-operation: abandons the partial window and the ramp; all outputs return to reset values immediately.
- adh_level persists across windows; only reset clears it.

Optional Feature:
- Macro ADH_BP_ALARM_EN.
- When defined:
  - In COMPUTE, bp_alarm sets to 1 if avg<=20 for two consecutive windows.
  - bp_alarm is sticky until rst.
  - A window with avg>20 clears the consecutive-window flag but not bp_alarm.
- When undefined: the bp_alarm port remains and is tied 0; no tracking logic is built.

Test Plan:
- Reset, then samples 40,40,40,40 with bp_valid held -> adh_target=20; adh_level steps 5,10,15,20; dose_req=1; ack -> IDLE, bp_ready back to 1 two cycles later.
- Boundaries, window all 20 -> target 100; all 45 -> 0; all 46 -> 0; all 21 -> 96.
- Truncation, window 21,22,22,22 (sum 87) -> avg 21 -> target 96. Ramp-down from 100 to 0 takes 20 RAMP cycles with no undershoot.
- Handshake: bp_valid toggled every other cycle -> only ready&&valid transfers are counted. dose_ack held low 10 cycles -> dose_req and adh_level held and bp_ready=0 throughout. dose_ack pulsed during RAMP -> ignored.
- rst asserted mid-RAMP (adh_level=35) -> all outputs 0 asynchronously; the next window starts a fresh ramp from 0.
- With ADH_BP_ALARM_EN, windows of avg 10, then 10 -> bp_alarm=1 after the second COMPUTE; a following window of avg 40 leaves it at 1. Without the macro, bp_alarm stays 0.
